dc_ramp_ctrl: RTL

//  Soft-start / direction-sequencing controller for the DC-motor PWM stage.

---
 rtl/dc_pkg.sv | 22 ++
 rtl/dc_tick_gen.sv | 31 +++
 rtl/dc_ramp_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dc_pkg.sv
// Shared types and helpers for the DC-motor soft-start / direction sequencer.
`timescale 1ns/1ps
package dc_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic [2:0] {IDLE, RAMP, BRAKE, DEAD, ESTOP} dc_state_t;

  // Clock cycles between two ramp steps.
  function automatic int tick_cycles(input int clk_fre, input int step_ms);
    return step_ms * 1000 * clk_fre;
  endfunction

  // Move cur toward goal by at most step; compare first so the result never wraps.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                    input logic [DUTY_W-1:0] goal,
                                                    input logic [DUTY_W-1:0] step);
    if (cur < goal) return ((goal - cur) > step) ? cur + step : goal;
    else            return ((cur - goal) > step) ? cur - step : goal;
  endfunction

endpackage

// File: rtl/dc_tick_gen.sv
// Free-running step-tick generator: one-cycle pulse every CLK_FRE*STEP_MS*1000 cycles.
`timescale 1ns/1ps
module dc_tick_gen import dc_pkg::*; #(
  parameter int CLK_FRE = 50,
  parameter int STEP_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int N  = tick_cycles(CLK_FRE, STEP_MS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(N - 1));
  assign tick = wrap;

  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dc_ramp_ctrl.sv
// Soft-start controller: slews PWM duty toward the commanded target and sequences
// direction reversals through ramp-down, dead time and flip.
`timescale 1ns/1ps
module dc_ramp_ctrl import dc_pkg::*; #(
  parameter int CLK_FRE    = 50,
  parameter int STEP_MS    = 20,
  parameter int DUTY_STEP  = 1,
  parameter int DEAD_TICKS = 5,
  parameter int DUTY_MAX   = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              estop,
  output logic              dc_dir,
  output logic [DUTY_W-1:0] dc_duty,
  output logic              busy,
  output logic              at_target
);

  localparam logic [DUTY_W-1:0] STEP_L   = DUTY_W'(DUTY_STEP);
  localparam logic [DUTY_W-1:0] MAX_L    = DUTY_W'(DUTY_MAX);
  localparam int                DEAD_W   = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;
  localparam logic [DEAD_W-1:0] DEAD_END = DEAD_W'(DEAD_TICKS - 1);

  dc_state_t         state_q, state_d;
  logic              dir_q, dir_d, tgt_dir_q, tgt_dir_d;
  logic [DUTY_W-1:0] duty_q, duty_d, tgt_duty_q, tgt_duty_d;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic              tick, accept, eff_dir;
  logic [DUTY_W-1:0] eff_duty, goal, new_duty;

  dc_tick_gen #(.CLK_FRE(CLK_FRE), .STEP_MS(STEP_MS)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign cmd_ready = (state_q == IDLE) || (state_q == RAMP) || (state_q == BRAKE);
  assign accept    = cmd_valid && cmd_ready;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    duty_d     = duty_q;
    tgt_dir_d  = tgt_dir_q;
    tgt_duty_d = tgt_duty_q;
    dead_d     = dead_q;
    // A command accepted on a tick edge already steers that tick's step.
    eff_dir    = accept ? cmd_dir : tgt_dir_q;
    eff_duty   = accept ? ((cmd_duty > MAX_L) ? MAX_L : cmd_duty) : tgt_duty_q;
    goal       = (eff_dir == dir_q) ? eff_duty : '0;
    new_duty   = (tick && state_q != IDLE) ? step_toward(duty_q, goal, STEP_L) : duty_q;

    if (estop) begin
      state_d    = ESTOP;
      duty_d     = '0;
      tgt_duty_d = '0;
      tgt_dir_d  = dir_q;
      dead_d     = '0;
    end else begin
      case (state_q)
        IDLE, RAMP, BRAKE: begin
          tgt_dir_d  = eff_dir;
          tgt_duty_d = eff_duty;
          duty_d     = new_duty;
          // RAMP and BRAKE differ only in their goal: the target, or zero before a reversal.
          if (eff_dir != dir_q) begin
            if (new_duty == '0) begin
              state_d = DEAD;
              dead_d  = '0;
            end else begin
              state_d = BRAKE;
            end
          end else if (new_duty == eff_duty) begin
            state_d = IDLE;
          end else begin
            state_d = RAMP;
          end
        end
        DEAD: begin
          if (tick) begin
            if (dead_q == DEAD_END) begin
              dir_d   = tgt_dir_q;
              dead_d  = '0;
              state_d = (tgt_duty_q != '0) ? RAMP : IDLE;
            end else begin
              dead_d = dead_q + DEAD_W'(1);
            end
          end
        end
        ESTOP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      duty_q     <= '0;
      tgt_dir_q  <= 1'b0;
      tgt_duty_q <= '0;
      dead_q     <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      duty_q     <= duty_d;
      tgt_dir_q  <= tgt_dir_d;
      tgt_duty_q <= tgt_duty_d;
      dead_q     <= dead_d;
    end
  end

  assign dc_dir    = dir_q;
  assign dc_duty   = duty_q;
  assign busy      = (state_q != IDLE);
  assign at_target = (state_q == IDLE) && (dir_q == tgt_dir_q) && (duty_q == tgt_duty_q);

endmodule
